// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg -- definitions shared by the LCD reader and the LCD writer.
//
// Holds the bus-access FSM state encoding (both engines walk the same
// SETUP / EN_HIGH / HOLD / RECOVER sequence) and the default bus timing
// in clock_50 cycles.
// ---------------------------------------------------------------------------
package lcd_pkg;

  // Bus-access FSM states
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_EN_HIGH = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_RECOVER = 3'd4;

  // Default bus timing, in clock_50 cycles
  localparam int DEF_T_SETUP   = 3;
  localparam int DEF_T_EN      = 25;
  localparam int DEF_T_HOLD    = 2;
  localparam int DEF_T_RECOVER = 30;

  // Default maximum number of busy-flag reads in one poll request
  localparam int DEF_POLL_MAX  = 1000;

endpackage

// File: rtl/lcd_reader.sv
// ---------------------------------------------------------------------------
// lcd_reader -- read engine for an HD44780-style character LCD.
//
// A request in IDLE starts one read cycle on the LCD bus: RS/RW settle, EN
// pulses high, the data bus is sampled on the last EN cycle, then RS/RW are
// held and the bus recovers. With rs_sel=0 and wait_bf=1 the engine keeps
// re-reading the status register until BF=0 or POLL_MAX reads were made.
//
// Ports
//   clock_50      in   clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   req           in   start a read (only honoured while ready=1)
//   rs_sel        in   0: busy-flag/address read, 1: DDRAM/CGRAM data read
//   wait_bf       in   with rs_sel=0, poll until BF=0
//   LCD_DATA_IN   in   [7:0] sampled LCD data bus
//   ready         out  engine idle, accepts req
//   valid         out  one-cycle pulse: result outputs are valid
//   rd_data       out  [7:0] last byte read
//   busy_flag     out  BF of the last status read
//   addr_counter  out  [6:0] address counter of the last status read
//   timeout       out  poll limit reached with BF still set
//   bus_own       out  this block drives the LCD pins
//   LCD_RW, LCD_RS, LCD_EN  out  LCD control pins
// ---------------------------------------------------------------------------
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int T_SETUP   = DEF_T_SETUP,
  parameter int T_EN      = DEF_T_EN,
  parameter int T_HOLD    = DEF_T_HOLD,
  parameter int T_RECOVER = DEF_T_RECOVER,
  parameter int POLL_MAX  = DEF_POLL_MAX
) (
  input  logic       clock_50,
  input  logic       reset_n,
  input  logic       req,
  input  logic       rs_sel,
  input  logic       wait_bf,
  input  logic [7:0] LCD_DATA_IN,
  output logic       ready,
  output logic       valid,
  output logic [7:0] rd_data,
  output logic       busy_flag,
  output logic [6:0] addr_counter,
  output logic       timeout,
  output logic       bus_own,
  output logic       LCD_RW,
  output logic       LCD_RS,
  output logic       LCD_EN
);

  localparam int CW = 16;
  localparam int PW = $clog2(POLL_MAX + 1);

  logic [2:0]    state, next_state;
  logic [CW-1:0] cnt, next_cnt;
  logic [PW-1:0] poll_cnt;
  logic          rs_q, wait_q, repoll;
  logic          cnt_zero, sample, limit_hit, terminate;
  logic          next_rs, next_access;

  assign cnt_zero  = (cnt == '0);
  assign sample    = (state == ST_EN_HIGH) && cnt_zero;
  // poll_cnt counts finished non-terminating reads, so the read in flight
  // is number poll_cnt+1
  assign limit_hit = (int'(poll_cnt) + 1) >= POLL_MAX;
  assign terminate = !wait_q || rs_q || !LCD_DATA_IN[7] || limit_hit;

  // rs_sel is latched on the accepting edge, so the pin value for the first
  // SETUP cycle has to come straight from the input
  assign next_rs     = (state == ST_IDLE) ? rs_sel : rs_q;
  assign next_access = (next_state == ST_SETUP) || (next_state == ST_EN_HIGH) ||
                       (next_state == ST_HOLD);

  // One shared down-counter times every phase; it is reloaded on each
  // phase change and otherwise counts down to zero.
  always_comb begin
    next_state = state;
    next_cnt   = cnt_zero ? cnt : cnt - 1'b1;
    case (state)
      ST_IDLE: begin
        if (req) begin
          next_state = ST_SETUP;
          next_cnt   = CW'(T_SETUP - 1);
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          next_state = ST_EN_HIGH;
          next_cnt   = CW'(T_EN - 1);
        end
      end
      ST_EN_HIGH: begin
        if (cnt_zero) begin
          next_state = ST_HOLD;
          next_cnt   = CW'(T_HOLD - 1);
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          next_state = ST_RECOVER;
          next_cnt   = CW'(T_RECOVER - 1);
        end
      end
      ST_RECOVER: begin
        if (cnt_zero) begin
          next_state = repoll ? ST_SETUP : ST_IDLE;
          next_cnt   = repoll ? CW'(T_SETUP - 1) : '0;
        end
      end
      default: begin
        next_state = ST_IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // Pin outputs are registered from the next-state decode so they are
  // glitch-free yet line up with the state register.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      rs_q         <= 1'b0;
      wait_q       <= 1'b0;
      repoll       <= 1'b0;
      poll_cnt     <= '0;
      ready        <= 1'b0;
      valid        <= 1'b0;
      rd_data      <= '0;
      busy_flag    <= 1'b0;
      addr_counter <= '0;
      timeout      <= 1'b0;
      bus_own      <= 1'b0;
      LCD_RW       <= 1'b0;
      LCD_RS       <= 1'b0;
      LCD_EN       <= 1'b0;
    end else begin
      state   <= next_state;
      cnt     <= next_cnt;
      ready   <= (next_state == ST_IDLE);
      bus_own <= next_access;
      LCD_RW  <= next_access;
      LCD_RS  <= next_access && next_rs;
      LCD_EN  <= (next_state == ST_EN_HIGH);
      valid   <= 1'b0;

      if (state == ST_IDLE && req) begin
        rs_q     <= rs_sel;
        wait_q   <= wait_bf;
        poll_cnt <= '0;
        repoll   <= 1'b0;
      end

      // Results only move on a terminating read; intermediate polls are
      // invisible outside apart from the extra EN pulses.
      if (sample) begin
        if (terminate) begin
          valid   <= 1'b1;
          repoll  <= 1'b0;
          rd_data <= LCD_DATA_IN;
          timeout <= wait_q && !rs_q && LCD_DATA_IN[7] && limit_hit;
          if (!rs_q) begin
            busy_flag    <= LCD_DATA_IN[7];
            addr_counter <= LCD_DATA_IN[6:0];
          end
        end else begin
          repoll   <= 1'b1;
          poll_cnt <= poll_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/lcd_reader.md
LCD_READER -- requirements
Module: lcd_reader

Interface
REQ-001 SHALL have parameter T_SETUP, default 3, meaning cycles RS/RW are stable before LCD_EN rises.
REQ-002 SHALL have parameter T_EN, default 25, meaning cycles LCD_EN is held high.
REQ-003 SHALL have parameter T_HOLD, default 2, meaning cycles RS/RW are held after LCD_EN falls.
REQ-004 SHALL have parameter T_RECOVER, default 30, meaning idle cycles before the next bus access.
REQ-005 SHALL have parameter POLL_MAX, default 1000, meaning the maximum busy-flag reads in one poll request.
REQ-006 SHALL have port clock_50 input 1: the single clock, rising edge.
REQ-007 SHALL have port reset_n input 1: reset, asynchronous and active-low.
REQ-008 SHALL have port req input 1: start a read, sampled only while ready=1.
REQ-009 SHALL have port rs_sel input 1: 0 selects the busy-flag/address read, 1 selects the DDRAM/CGRAM data read.
REQ-010 SHALL have port wait_bf input 1: with rs_sel=0, repeat reads until BF=0.
REQ-011 SHALL have port LCD_DATA_IN input 8: the sampled LCD data bus.
REQ-012 SHALL have port ready output 1: the engine is idle and accepts req.
REQ-013 SHALL have port valid output 1: one-cycle pulse marking rd_data, busy_flag, addr_counter and timeout as valid.
REQ-014 SHALL have port rd_data output 8: the last byte read.
REQ-015 SHALL have port busy_flag output 1, equal to rd_data[7] when rs_sel=0.
REQ-016 SHALL have port addr_counter output 7, equal to rd_data[6:0] when rs_sel=0.
REQ-017 SHALL have port timeout output 1: poll limit reached, valid only with valid.
REQ-018 SHALL have port bus_own output 1: this block owns the LCD pins, so the top level tri-states the writer.
REQ-019 SHALL have ports LCD_RW, LCD_RS and LCD_EN, each output 1, driving the LCD control pins.

Function
REQ-020 SHALL implement FSM states IDLE, SETUP, EN_HIGH, HOLD and RECOVER.
REQ-021 SHALL assert ready only in IDLE.
REQ-022 SHALL move IDLE->SETUP on req=1 and latch rs_sel and wait_bf at that edge.
REQ-023 SHALL hold bus_own=1 and LCD_RW=1, with LCD_RS equal to latched rs_sel, from SETUP through HOLD.
REQ-024 SHALL drive LCD_RW=0, LCD_RS=0 and bus_own=0 in IDLE and RECOVER.
REQ-025 SHALL stay T_SETUP cycles in SETUP, T_EN cycles in EN_HIGH with LCD_EN=1, T_HOLD cycles in HOLD and T_RECOVER cycles in RECOVER, using one shared down-counter.
REQ-026 SHALL register LCD_DATA_IN into rd_data on the final EN_HIGH cycle (the EN_HIGH->HOLD edge).
REQ-027 SHALL pulse valid during the first HOLD cycle of a terminating read: req accepted at edge k gives valid at cycle k+1+T_SETUP+T_EN (k+29 at defaults).
REQ-028 SHALL make a read terminating when latched wait_bf=0, or rs_sel=1, or the sampled BF=0, or the poll count has reached POLL_MAX.
REQ-029 SHALL, for a non-terminating poll, suppress valid, increment the poll counter and go RECOVER->SETUP instead of RECOVER->IDLE.
REQ-030 SHALL clear the poll counter on acceptance.
REQ-031 SHALL set timeout=1 only when the final poll read returns BF=1 at count POLL_MAX.
REQ-032 SHALL make ready return at cycle k+1+T_SETUP+T_EN+T_HOLD+T_RECOVER (k+61 at defaults).
REQ-033 SHALL ignore req while ready=0, with no queuing.
REQ-034 SHALL leave rd_data, busy_flag, addr_counter and timeout unchanged between valid pulses.
REQ-035 SHALL never raise LCD_EN while LCD_RS/LCD_RW are changing, and SHALL keep rs_sel constant for a whole request, including all polls.

Reset
REQ-036 SHALL, on reset_n=0, asynchronously enter IDLE.
REQ-037 SHALL, on reset_n=0, force LCD_EN=0, LCD_RW=0, LCD_RS=0, bus_own=0, valid=0, timeout=0, rd_data=0, busy_flag=0 and addr_counter=0.
REQ-038 SHALL, on reset during any bus access, drop LCD_EN in the same cycle and produce no valid pulse.
REQ-039 SHALL set ready=1 on the first clock_50 edge after reset_n deasserts.

Structure
REQ-040 SHALL place the FSM state encoding and default timing constants in shared package lcd_pkg, which the LCD writer also uses.
REQ-041 SHALL be one module with no sub-module; any bus tri-state buffer lives in the top level.

Verification
REQ-042 SHALL verify a single status read: req=1, rs_sel=0, wait_bf=0, LCD_DATA_IN=8'h45 -> valid at k+29, busy_flag=0, addr_counter=7'h45, ready at k+61.
REQ-043 SHALL verify a data read: rs_sel=1, LCD_DATA_IN=8'h41 -> LCD_RS=1 for SETUP through HOLD, rd_data=8'h41, LCD_EN high for exactly 25 cycles.
REQ-044 SHALL verify polling: wait_bf=1, BF=1 for 3 reads then 8'h12 -> four EN pulses, one valid, busy_flag=0, addr_counter=7'h12, timeout=0.
REQ-045 SHALL verify poll timeout: POLL_MAX=4, BF always 1 -> exactly 4 EN pulses, valid with timeout=1 and busy_flag=1.
REQ-046 SHALL verify mid-access reset: reset_n=0 at cycle 10 of EN_HIGH -> LCD_EN=0 and bus_own=0 immediately, no valid, ready=1 after release.
REQ-047 SHALL verify ignored req: req pulsed at k+5 while busy -> no second access, ready exactly once at k+61.
